// File: rtl/codemem_load_ctrl_pkg.sv
// Shared constants for the code-memory loader: memory geometry, state encoding, address helper.
// ST_CHECK exists only when CODEMEM_LOAD_CHECKSUM_EN is defined.
package codemem_load_ctrl_pkg;

    localparam int CODE_WORDS = 64;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
`ifdef CODEMEM_LOAD_CHECKSUM_EN
    localparam logic [1:0] ST_CHECK = 2'd2;
`endif
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Address arithmetic wraps within the code memory, matching the 6-bit write port.
    function automatic logic [ADDR_W-1:0] word_addr(input int base, input logic [ADDR_W-1:0] offset);
        return ADDR_W'(base) + offset;
    endfunction

endpackage

// File: rtl/codemem_load_sum.sv
// Modulo-2^16 running sum of the data words accepted in a load session.
// Compiled only with CODEMEM_LOAD_CHECKSUM_EN defined.
`ifdef CODEMEM_LOAD_CHECKSUM_EN
module codemem_load_sum
    import codemem_load_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_q + add_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule
`endif

// File: rtl/codemem_load_ctrl.sv
// Streams instruction words into code memory while holding the CPU off.
// CODEMEM_LOAD_CHECKSUM_EN adds a trailing checksum word verified in the CHECK state.
module codemem_load_ctrl
    import codemem_load_ctrl_pkg::*;
#(
    parameter int BASE_ADDR = 32,
    parameter int MAX_WORDS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic [ADDR_W-1:0] load_count,
    output logic              error
);

    // A misconfigured region is clamped so the loader never wraps past the top of memory.
    localparam int MAX_EFF = (BASE_ADDR + MAX_WORDS > CODE_WORDS) ? (CODE_WORDS - BASE_ADDR) : MAX_WORDS;
    localparam logic [ADDR_W:0]   MAX_LIM = (ADDR_W+1)'(MAX_EFF);
    localparam logic [ADDR_W-1:0] MAX_M1  = ADDR_W'(MAX_EFF - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              error_q, error_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready;
    logic              xfer;
    logic              data_xfer;

`ifdef CODEMEM_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    codemem_load_sum u_sum (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_q == ST_IDLE && load_start),
        .add_en   (data_xfer),
        .add_data (load_data),
        .sum      (sum)
    );

    assign ready = (state_q == ST_LOAD && {1'b0, count_q} < MAX_LIM) || (state_q == ST_CHECK);
`else
    assign ready = (state_q == ST_LOAD && {1'b0, count_q} < MAX_LIM);
`endif

    assign xfer      = load_valid && ready;
    assign data_xfer = xfer && (state_q == ST_LOAD);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        error_d = error_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    error_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (data_xfer) begin
                    we_d    = 1'b1;
                    waddr_d = word_addr(BASE_ADDR, count_q);
                    wdata_d = load_data;
                    count_d = count_q + 1'b1;
                    if (load_last) begin
`ifdef CODEMEM_LOAD_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else if (count_q == MAX_M1) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
`ifdef CODEMEM_LOAD_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    if (load_data != sum) begin
                        error_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            error_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            error_q <= error_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Gating with reset drops a pending write in the very cycle reset arrives.
    assign mem_we     = we_q && !reset;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign load_ready = ready;
    assign cpu_run    = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign load_count = count_q;
    assign error      = error_q;

endmodule

// File: tb/tb_codemem_load_ctrl.sv
// Directed self-checking bench for codemem_load_ctrl; covers both builds of CODEMEM_LOAD_CHECKSUM_EN.
module tb_codemem_load_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        mem_we;
    logic [5:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic        cpu_run;
    logic        busy;
    logic [5:0]  load_count;
    logic        error;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    logic [5:0]  wr_addr [256];
    logic [15:0] wr_data [256];

    codemem_load_ctrl #(.BASE_ADDR(32), .MAX_WORDS(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .load_count (load_count),
        .error      (error)
    );

    always #5 clock = ~clock;

    // Memory-side view: every write the code memory would capture.
    always @(posedge clock) begin
        if (mem_we) begin
            wr_addr[wr_total[7:0]] <= mem_waddr;
            wr_data[wr_total[7:0]] <= mem_wdata;
            wr_total <= wr_total + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStart();
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic last);
        int waited;
        waited     = 0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        while (!load_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!load_ready) begin
            checkOutput("handshake_timeout", 32'(load_ready), 32'd1);
        end else begin
            @(negedge clock);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int bad_run;
        logic [15:0] t1_words [3];
        logic [15:0] t2_words [3];
        t1_words = '{16'h1111, 16'h2222, 16'h3333};
        t2_words = '{16'hA5A5, 16'h0F0F, 16'hFFFF};

        reset      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 16'h0;
        repeat (3) @(negedge clock);

        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_waddr", 32'(mem_waddr), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_count", 32'(load_count), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_ready", 32'(load_ready), 32'd0);
        checkOutput("rst_cpu_run", 32'(cpu_run), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Basic three-word session
        base = wr_total;
        applyStart();
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_run_low", 32'(cpu_run), 32'd0);
        checkOutput("t1_ready", 32'(load_ready), 32'd1);
        applyStimulus(16'h1111, 1'b0);
        applyStimulus(16'h2222, 1'b0);
        applyStimulus(16'h3333, 1'b1);
`ifdef CODEMEM_LOAD_CHECKSUM_EN
        applyStimulus(16'h6666, 1'b0);
        checkOutput("t1_cksum_not_written", 32'(mem_we), 32'd0);
`else
        checkOutput("t1_last_we", 32'(mem_we), 32'd1);
        checkOutput("t1_last_addr", 32'(mem_waddr), 32'd34);
`endif
        checkOutput("t1_run_at_1", 32'(cpu_run), 32'd0);
        @(negedge clock);
        checkOutput("t1_run_at_2", 32'(cpu_run), 32'd1);
        checkOutput("t1_busy_end", 32'(busy), 32'd0);
        checkOutput("t1_we_idle", 32'(mem_we), 32'd0);
        checkOutput("t1_addr_hold", 32'(mem_waddr), 32'd34);
        checkOutput("t1_count", 32'(load_count), 32'd3);
        checkOutput("t1_error", 32'(error), 32'd0);
        checkOutput("t1_nwrites", 32'(wr_total - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t1_waddr", 32'(wr_addr[8'(base + i)]), 32'(32 + i));
            checkOutput("t1_wdata", 32'(wr_data[8'(base + i)]), 32'(t1_words[i]));
        end

        // Five-cycle gaps between words
        base    = wr_total;
        bad_run = 0;
        applyStart();
        for (int i = 0; i < 3; i++) begin
            repeat (5) begin
                @(negedge clock);
                if (cpu_run) bad_run++;
            end
            checkOutput("t2_gap_writes", 32'(wr_total - base), 32'(i));
            applyStimulus(t2_words[i], i == 2);
        end
`ifdef CODEMEM_LOAD_CHECKSUM_EN
        applyStimulus(16'hB4B3, 1'b0);
`endif
        @(negedge clock);
        checkOutput("t2_run_low_cycles", 32'(bad_run), 32'd0);
        checkOutput("t2_nwrites", 32'(wr_total - base), 32'd3);
        checkOutput("t2_count", 32'(load_count), 32'd3);
        checkOutput("t2_error", 32'(error), 32'd0);
        checkOutput("t2_last_data", 32'(wr_data[8'(base + 2)]), 32'h0000FFFF);

        // Overflow: 33 words without load_last
        base = wr_total;
        applyStart();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(16'(16'h1000 + i), 1'b0);
        end
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        checkOutput("t3_no_ready", 32'(load_ready), 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("t3_nwrites", 32'(wr_total - base), 32'd32);
        checkOutput("t3_first_addr", 32'(wr_addr[8'(base)]), 32'd32);
        checkOutput("t3_last_addr", 32'(wr_addr[8'(base + 31)]), 32'd63);
        checkOutput("t3_last_data", 32'(wr_data[8'(base + 31)]), 32'h0000101F);
        checkOutput("t3_error", 32'(error), 32'd1);
        checkOutput("t3_idle", 32'(busy), 32'd0);
        checkOutput("t3_cpu_run", 32'(cpu_run), 32'd1);
        checkOutput("t3_count", 32'(load_count), 32'd32);
        checkOutput("t3_ready_idle", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        @(negedge clock);

        // Reset right after a handshake drops the pending write
        base = wr_total;
        applyStart();
        checkOutput("t4_error_cleared", 32'(error), 32'd0);
        checkOutput("t4_count_cleared", 32'(load_count), 32'd0);
        applyStimulus(16'h7777, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("t4_we_dropped", 32'(mem_we), 32'd0);
        @(negedge clock);
        checkOutput("t4_idle", 32'(busy), 32'd0);
        checkOutput("t4_cpu_run", 32'(cpu_run), 32'd1);
        checkOutput("t4_count", 32'(load_count), 32'd0);
        checkOutput("t4_waddr", 32'(mem_waddr), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t4_nwrites", 32'(wr_total - base), 32'd0);

        // load_start during LOAD is ignored
        base = wr_total;
        applyStart();
        applyStimulus(16'hAAAA, 1'b0);
        applyStimulus(16'hBBBB, 1'b0);
        applyStart();
        checkOutput("t5_count_kept", 32'(load_count), 32'd2);
        checkOutput("t5_still_load", 32'(load_ready), 32'd1);
        applyStimulus(16'hCCCC, 1'b1);
`ifdef CODEMEM_LOAD_CHECKSUM_EN
        applyStimulus(16'h3331, 1'b0);
`endif
        @(negedge clock);
        checkOutput("t5_count", 32'(load_count), 32'd3);
        checkOutput("t5_nwrites", 32'(wr_total - base), 32'd3);
        checkOutput("t5_addr3", 32'(wr_addr[8'(base + 2)]), 32'd34);
        checkOutput("t5_data3", 32'(wr_data[8'(base + 2)]), 32'h0000CCCC);

`ifdef CODEMEM_LOAD_CHECKSUM_EN
        // Checksum match then mismatch
        for (int r = 0; r < 2; r++) begin
            base = wr_total;
            applyStart();
            applyStimulus(16'h0001, 1'b0);
            applyStimulus(16'h0002, 1'b1);
            applyStimulus(16'(3 + r), 1'b0);
            @(negedge clock);
            checkOutput("t6_error", 32'(error), 32'(r));
            checkOutput("t6_nwrites", 32'(wr_total - base), 32'd2);
            checkOutput("t6_count", 32'(load_count), 32'd2);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/codemem_load_ctrl.md
CODEMEM_LOAD_CTRL -- requirements
Module: codemem_load_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32, first code-memory address written; user region start.
REQ-002 SHALL have parameter MAX_WORDS, default 32, maximum words per load; BASE_ADDR+MAX_WORDS <= 64.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on posedge clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port load_start  in  1  one-cycle pulse that begins a load session.
REQ-006 SHALL have port load_valid  in  1  source presents a word on load_data.
REQ-007 SHALL have port load_data  in  16  instruction word from the source.
REQ-008 SHALL have port load_last  in  1  qualifies the final word of the session.
REQ-009 SHALL have port load_ready  out  1  controller accepts a word this cycle.
REQ-010 SHALL have port mem_we  out  1  code-memory write enable (drives c1).
REQ-011 SHALL have port mem_waddr  out  6  code-memory write address.
REQ-012 SHALL have port mem_wdata  out  16  code-memory write data.
REQ-013 SHALL have port cpu_run  out  1  CPU fetch enable; low while the memory is owned by the loader.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port load_count  out  6  words written in the current or most recent session.
REQ-016 SHALL have port error  out  1  sticky session error flag.

Function
REQ-017 SHALL implement states IDLE, LOAD, CHECK, DONE.
REQ-018 IDLE->LOAD on load_start; load_count and error SHALL clear on that edge; load_start in any other state SHALL be ignored.
REQ-019 load_ready SHALL be high only in LOAD with load_count < MAX_WORDS; a word transfers when load_valid and load_ready are both high.
REQ-020 Each transfer SHALL produce exactly one mem_we pulse on the following cycle: mem_waddr = BASE_ADDR + load_count (pre-increment), mem_wdata = the accepted word; load_count increments with the pulse.
REQ-021 A transfer with load_last SHALL move LOAD->CHECK when the macro is enabled, otherwise LOAD->DONE.
REQ-022 load_count reaching MAX_WORDS without load_last SHALL set error and move to DONE; further load_valid SHALL be left unacknowledged.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE; this cycle guarantees the last mem_we completes before cpu_run rises.
REQ-024 cpu_run SHALL be low in LOAD, CHECK and DONE and high in IDLE.
REQ-025 load_valid low in LOAD SHALL stall indefinitely with no timeout.
REQ-026 mem_we SHALL be low whenever no write is pending; mem_waddr and mem_wdata SHALL hold their last values.

Reset
REQ-027 Reset SHALL force IDLE, mem_we=0, mem_waddr=0, mem_wdata=0, load_count=0, error=0, load_ready=0, cpu_run=1, busy=0.
REQ-028 Reset mid-session SHALL abort it; a write already pending SHALL be dropped; memory contents are not restored by this block.

Configuration
REQ-029 With CODEMEM_LOAD_CHECKSUM_EN defined, a 16-bit modulo-2^16 sum of accepted data words SHALL be kept; in CHECK, one further handshaken word is the checksum; mismatch sets error; CHECK->DONE; it SHALL not be written to memory.
REQ-030 Without CODEMEM_LOAD_CHECKSUM_EN, CHECK and the sum register SHALL be absent; behaviour is otherwise identical.

Structure
REQ-031 State encoding and the CODE_WORDS=64 / ADDR_W=6 constants SHALL live in the shared cpu package.
REQ-032 The checksum accumulator SHALL be a sub-module codemem_load_sum, instantiated only under the macro.

Verification
REQ-033 Reset then start, 3 words 0x1111,0x2222,0x3333 (last on third) -> mem_we at addrs 32,33,34 with those data, load_count=3, error=0, cpu_run high 2 cycles after the third handshake.
REQ-034 load_valid gaps of 5 cycles between words -> no spurious mem_we, cpu_run stays low throughout.
REQ-035 33 words offered without load_last -> 32 writes (addr 32..63), 33rd not acknowledged, error=1, return to IDLE.
REQ-036 Reset asserted the cycle after a handshake -> no mem_we, IDLE, cpu_run=1, load_count=0.
REQ-037 Macro on, words 0x0001,0x0002 then checksum 0x0003 -> error=0; repeat with checksum 0x0004 -> error=1, exactly 2 writes each run.
REQ-038 load_start pulsed during LOAD -> ignored, load_count not cleared.
